// File: rtl/sd_cmd_phys_if.sv
// SD command PHY port bundle: host request/status side plus the CMD pin signals.
interface sd_cmd_phys_if;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic [127:0] response;
  logic         crc_err;
  logic         timeout_err;
  logic         end_err;
  logic         cmd_pin_in;
  logic         cmd_pin_out;
  logic         cmd_oe;
  logic         sd_clk_en;

  modport master (
    output start, cmd_index, cmd_argument, resp_type, cmd_pin_in,
    input  busy, done, response, crc_err, timeout_err, end_err,
           cmd_pin_out, cmd_oe, sd_clk_en
  );

  modport slave (
    input  start, cmd_index, cmd_argument, resp_type, cmd_pin_in,
    output busy, done, response, crc_err, timeout_err, end_err,
           cmd_pin_out, cmd_oe, sd_clk_en
  );
endinterface

// File: rtl/sd_cmd_phys.sv
// SD CMD-line PHY: serialises a 48-bit command with CRC7 and captures the
// 48- or 136-bit response, reporting CRC, timeout and end-bit errors.
module sd_cmd_phys #(
  parameter int CLK_DIV      = 2,
  parameter int RESP_TIMEOUT = 64,
  parameter bit CRC_CHECK    = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  sd_cmd_phys_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, FINISH} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]  div_q;
  logic [47:0]    tx_q;
  logic [7:0]     bit_cnt_q;
  logic [TW-1:0]  wait_q;
  logic [126:0]   rx_q;
  logic [1:0]     type_q;
  logic           oe_q, pin_q, busy_q, done_q;
  logic           crc_err_q, to_err_q, end_err_q;
  logic [127:0]   resp_q;

  logic           tick, is_long;
  logic           send_done, wait_start, wait_expire, recv_last;
  logic [39:0]    cmd_body;
  logic [47:0]    tx_load;
  logic [127:0]   rx_next;
  logic [119:0]   crc_data;
  logic [127:0]   rx_resp;
  logic           rx_crc_bad;

  // Serial CRC7 (x^7+x^3+1, init 0); leading zeros leave a zero state
  // untouched, so short fields are right-aligned into the 120-bit input.
  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign tick     = (div_q == CW'(CLK_DIV - 1));
  assign is_long  = (type_q == 2'b10);
  assign cmd_body = {2'b01, bus.cmd_index, bus.cmd_argument};
  assign tx_load  = {cmd_body, crc7({80'b0, cmd_body}), 1'b1};
  assign rx_next  = {rx_q, bus.cmd_pin_in};

  assign send_done   = (state_q == SEND) && tick && (bit_cnt_q == 8'd48);
  assign wait_start  = (state_q == WAIT_RESP) && tick && !bus.cmd_pin_in;
  assign wait_expire = (state_q == WAIT_RESP) && tick && bus.cmd_pin_in &&
                       (wait_q == TW'(RESP_TIMEOUT - 1));
  assign recv_last   = (state_q == RECV) && tick && (bit_cnt_q == 8'd1);

  always_comb begin
    crc_data   = is_long ? rx_next[127:8] : {80'b0, rx_next[47:8]};
    rx_resp    = is_long ? {8'b0, rx_next[127:8]}
                         : {90'b0, rx_next[45:40], rx_next[39:8]};
    rx_crc_bad = CRC_CHECK && (type_q != 2'b11) && (crc7(crc_data) != rx_next[7:1]);
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.start) state_d = SEND;
      SEND:      if (send_done) state_d = (type_q == 2'b00) ? FINISH : WAIT_RESP;
      WAIT_RESP: if (wait_start) state_d = RECV;
                 else if (wait_expire) state_d = FINISH;
      RECV:      if (recv_last) state_d = FINISH;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      tx_q      <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
      rx_q      <= '0;
      type_q    <= '0;
      oe_q      <= 1'b0;
      pin_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      end_err_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      div_q  <= tick ? '0 : div_q + CW'(1);
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          tx_q      <= tx_load;
          type_q    <= bus.resp_type;
          busy_q    <= 1'b1;
          bit_cnt_q <= '0;
          wait_q    <= '0;
          rx_q      <= '0;
          resp_q    <= '0;
          crc_err_q <= 1'b0;
          to_err_q  <= 1'b0;
          end_err_q <= 1'b0;
        end
        // First tick raises oe with the start bit; the tick after the end bit releases the line.
        SEND: if (tick) begin
          if (send_done) begin
            oe_q  <= 1'b0;
            pin_q <= 1'b1;
            if (type_q == 2'b00) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end else begin
            oe_q      <= 1'b1;
            pin_q     <= tx_q[47];
            tx_q      <= {tx_q[46:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 8'd1;
          end
        end
        WAIT_RESP: if (tick) begin
          if (wait_start) begin
            bit_cnt_q <= is_long ? 8'd135 : 8'd47;
          end else if (wait_expire) begin
            to_err_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        RECV: if (tick) begin
          rx_q      <= rx_next[126:0];
          bit_cnt_q <= bit_cnt_q - 8'd1;
          if (recv_last) begin
            resp_q    <= rx_resp;
            crc_err_q <= rx_crc_bad;
            end_err_q <= !bus.cmd_pin_in;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sd_clk_en   = tick;
  assign bus.cmd_oe      = oe_q;
  assign bus.cmd_pin_out = pin_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.response    = resp_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.timeout_err = to_err_q;
  assign bus.end_err     = end_err_q;
endmodule

// File: tb/tb_sd_cmd_phys.sv
// Bench for sd_cmd_phys: directed commands with a card model; expected frames
// and completions are queued and checked by a separate negedge monitor.
module tb_sd_cmd_phys;
  localparam int CLK_DIV      = 4;
  localparam int RESP_TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sd_cmd_phys_if bus();

  sd_cmd_phys #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .CRC_CHECK(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [127:0] resp;
    logic         crc;
    logic         tmo;
    logic         ee;
    bit           chk_lat;
  } exp_done_t;

  logic [47:0] exp_frame_q[$];
  exp_done_t   exp_done_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  localparam logic [119:0] CID = 120'h0353445344313647801234567801AB;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC7 over the low n bits of d, MSB first.
  function automatic logic [6:0] ref_crc7(input logic [119:0] d, input int n);
    logic [6:0] r = 7'h00;
    for (int i = n - 1; i >= 0; i--) begin
      if (d[i] ^ r[6]) r = {r[5:0], 1'b0} ^ 7'h09;
      else             r = {r[5:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] b = {2'b01, idx, arg};
    return {b, ref_crc7({80'b0, b}, 40), 1'b1};
  endfunction

  function automatic exp_done_t mk_done(input logic [127:0] r, input logic c, input logic t,
                                        input logic e, input bit lat);
    exp_done_t x;
    x.resp = r; x.crc = c; x.tmo = t; x.ee = e; x.chk_lat = lat;
    return x;
  endfunction

  // Monitor: rebuilds the serial frame, checks pin alignment and every completion.
  logic [47:0] cap, f;
  int          cap_n, oe_fall_cyc;
  logic        oe_prev, pin_prev, en_prev;
  bit          prev_valid;
  exp_done_t   ed;

  initial begin
    cap = '0; cap_n = 0; oe_prev = 1'b0; oe_fall_cyc = 0;
    pin_prev = 1'b1; en_prev = 1'b0; prev_valid = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        cap_n = 0; cap = '0; prev_valid = 0;
      end else begin
        if (prev_valid && bus.cmd_pin_out !== pin_prev)
          check("pin_change_after_tick", en_prev, 1);
        if (bus.cmd_oe && bus.sd_clk_en) begin
          cap = {cap[46:0], bus.cmd_pin_out};
          cap_n++;
        end
        if (oe_prev && !bus.cmd_oe) begin
          oe_fall_cyc = cyc;
          if (exp_frame_q.size() == 0) check("unexpected_frame", 1, 0);
          else begin
            f = exp_frame_q.pop_front();
            check("frame", cap, f);
            check("frame_oe_ticks", 128'(cap_n), 48);
          end
          cap_n = 0;
        end
        if (bus.done) begin
          if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            ed = exp_done_q.pop_front();
            check("response", bus.response, ed.resp);
            check("crc_err", bus.crc_err, ed.crc);
            check("timeout_err", bus.timeout_err, ed.tmo);
            check("end_err", bus.end_err, ed.ee);
            check("busy_clear_at_done", bus.busy, 0);
            if (ed.chk_lat)
              check("timeout_latency", 128'(cyc - oe_fall_cyc), 128'(RESP_TIMEOUT * CLK_DIV));
          end
        end
        prev_valid = 1;
      end
      oe_prev  = bus.cmd_oe;
      pin_prev = bus.cmd_pin_out;
      en_prev  = bus.sd_clk_en;
    end
  end

  task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    @(negedge clock);
    bus.cmd_index = idx; bus.cmd_argument = arg; bus.resp_type = rt; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_oe(input logic v, output bit ok);
    ok = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clock);
      if (bus.cmd_oe === v) ok = 1;
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clock);
      if (bus.done) ok = 1;
    end
    check(name, ok, 1);
  endtask

  // Card model: after the command ends, drive nbits of fr (MSB first), one per tick.
  task automatic card_reply(input logic [135:0] fr, input int nbits);
    bit ok1, ok2, got;
    bit budget_hit = 0;
    wait_oe(1'b1, ok1);
    wait_oe(1'b0, ok2);
    for (int i = nbits - 1; i >= 0 && ok1 && ok2; i--) begin
      bus.cmd_pin_in = fr[i];
      got = 0;
      for (int k = 0; k < 4 * CLK_DIV && !got; k++) begin
        @(negedge clock);
        if (bus.sd_clk_en) got = 1;
      end
      if (!got) budget_hit = 1;
      @(posedge clock);
      #1;
    end
    bus.cmd_pin_in = 1'b1;
    check("card_reply_budget", {budget_hit, ok1, ok2}, 3'b011);
  endtask

  initial begin
    logic [47:0]  r8_ok, r8_bad;
    logic [135:0] r2;
    int           n;
    bit           ok;
    bus.start = 1'b0; bus.cmd_index = '0; bus.cmd_argument = '0; bus.resp_type = '0;
    bus.cmd_pin_in = 1'b1;
    r8_ok  = 48'h08_0000_01AA_13;
    r8_bad = 48'h08_0000_01AA_17;
    r2     = {8'h3F, CID, ref_crc7(CID, 120), 1'b1};

    repeat (3) @(negedge clock);
    check("rst_cmd_oe", bus.cmd_oe, 0);
    check("rst_cmd_pin_out", bus.cmd_pin_out, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_response", bus.response, 0);
    check("rst_flags", {bus.crc_err, bus.timeout_err, bus.end_err}, 0);
    check("rst_sd_clk_en", bus.sd_clk_en, 0);
    reset = 1'b0;
    n = 0; ok = 0;
    for (int k = 0; k < 4 * CLK_DIV && !ok; k++) begin
      @(negedge clock);
      n++;
      if (bus.sd_clk_en) ok = 1;
    end
    check("first_tick_after_reset", 128'(n), 128'(CLK_DIV - 1));

    // CMD0, no response
    exp_frame_q.push_back(48'h40_0000_0000_95);
    exp_done_q.push_back(mk_done('0, 0, 0, 0, 0));
    pulse_start(6'd0, 32'h0, 2'b00);
    wait_done("done_cmd0");

    // CMD8 with R7 reply
    exp_frame_q.push_back(48'h48_0000_01AA_87);
    exp_done_q.push_back(mk_done(128'h08_0000_01AA, 0, 0, 0, 0));
    pulse_start(6'd8, 32'h0000_01AA, 2'b01);
    card_reply({88'b0, r8_ok}, 48);
    wait_done("done_cmd8");

    // CMD17, card silent
    exp_frame_q.push_back(mk_cmd(6'd17, 32'h0));
    exp_done_q.push_back(mk_done('0, 0, 1, 0, 1));
    pulse_start(6'd17, 32'h0, 2'b01);
    wait_done("done_cmd17_timeout");

    // Corrupted CRC: flagged for type 01, ignored for type 11
    exp_frame_q.push_back(48'h48_0000_01AA_87);
    exp_done_q.push_back(mk_done(128'h08_0000_01AA, 1, 0, 0, 0));
    pulse_start(6'd8, 32'h0000_01AA, 2'b01);
    card_reply({88'b0, r8_bad}, 48);
    wait_done("done_crc_bad_r1");
    exp_frame_q.push_back(48'h48_0000_01AA_87);
    exp_done_q.push_back(mk_done(128'h08_0000_01AA, 0, 0, 0, 0));
    pulse_start(6'd8, 32'h0000_01AA, 2'b11);
    card_reply({88'b0, r8_bad}, 48);
    wait_done("done_crc_bad_r3");

    // CMD2 with R2 (CID), then with a bad end bit
    exp_frame_q.push_back(mk_cmd(6'd2, 32'h0));
    exp_done_q.push_back(mk_done({8'h00, CID}, 0, 0, 0, 0));
    pulse_start(6'd2, 32'h0, 2'b10);
    card_reply(r2, 136);
    wait_done("done_cmd2");
    exp_frame_q.push_back(mk_cmd(6'd2, 32'h0));
    exp_done_q.push_back(mk_done({8'h00, CID}, 0, 0, 1, 0));
    pulse_start(6'd2, 32'h0, 2'b10);
    card_reply({r2[135:1], 1'b0}, 136);
    wait_done("done_cmd2_end_err");

    // Reset at tick 20 of SEND
    pulse_start(6'd8, 32'h0000_01AA, 2'b00);
    wait_oe(1'b1, ok);
    check("send_started", ok, 1);
    n = 0;
    for (int k = 0; k < 40 * CLK_DIV && n < 20; k++) begin
      @(negedge clock);
      if (bus.sd_clk_en) n++;
    end
    reset = 1'b1;
    @(negedge clock);
    check("midreset_cmd_oe", bus.cmd_oe, 0);
    check("midreset_busy", bus.busy, 0);
    check("midreset_pin", bus.cmd_pin_out, 1);
    reset = 1'b0;

    // Fresh command with start pulses while busy
    exp_frame_q.push_back(48'h48_0000_01AA_87);
    exp_done_q.push_back(mk_done('0, 0, 0, 0, 0));
    pulse_start(6'd8, 32'h0000_01AA, 2'b00);
    for (int k = 0; k < 3; k++) pulse_start(6'd5, 32'hFFFF_FFFF, 2'b01);
    wait_done("done_after_reset");

    // Start held through the done cycle: ignored there, accepted one cycle later
    exp_frame_q.push_back(48'h40_0000_0000_95);
    exp_done_q.push_back(mk_done('0, 0, 0, 0, 0));
    bus.cmd_index = 6'd0; bus.cmd_argument = 32'h0; bus.resp_type = 2'b00; bus.start = 1'b1;
    @(negedge clock);
    check("start_at_done_ignored", bus.busy, 0);
    @(negedge clock);
    check("start_after_done_accepted", bus.busy, 1);
    bus.start = 1'b0;
    wait_done("done_back_to_back");

    repeat (4) @(negedge clock);
    check("frames_left", 128'(exp_frame_q.size()), 0);
    check("dones_left", 128'(exp_done_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
